// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment driver: slot scanning with an anti-ghosting
// blank, hex decode, frame-synchronous double buffering. SEG7_DIM_EN adds PWM dimming.
module seg7_scan_ctrl #(
  parameter int PRESCALE  = 3750,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data_i,
  input  logic [7:0]  disp_dp_i,
  input  logic [7:0]  disp_en_i,
  input  logic        disp_update_i,
`ifdef SEG7_DIM_EN
  input  logic [3:0]  brightness_i,
`endif
  output logic        pend_o,
  output logic        frame_done_o,
  output logic [7:0]  sev_cathode_o,
  output logic [7:0]  sev_anode_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   slot_cnt_reg, slot_cnt_next;
  logic [2:0]      digit_reg, digit_next;
  logic            slot_wrap;
  logic            frame_bnd;

  logic [31:0]     pend_data_reg, pend_data_next;
  logic [7:0]      pend_dp_reg, pend_dp_next;
  logic [7:0]      pend_en_reg, pend_en_next;
  logic            pend_reg, pend_next;

  logic [31:0]     shadow_data_reg, shadow_data_next;
  logic [7:0]      shadow_dp_reg, shadow_dp_next;
  logic [7:0]      shadow_en_reg, shadow_en_next;

  logic [7:0]      anode_reg, anode_next;
  logic [7:0]      cathode_reg, cathode_next;
  logic            frame_done_reg;

  logic [3:0]      shadow_nib [8];
  logic [7:0]      digit_hit;
  logic [3:0]      cur_nib;
  logic            cur_dp;
  logic [6:0]      seg_raw;
  logic            pwm_on;

  // ---------------------------------------------------------------------------
  // Slot / digit sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_wrap     = (slot_cnt_reg == SLOT_LAST);
    frame_bnd     = slot_wrap && (digit_reg == 3'd7);
    slot_cnt_next = slot_wrap ? '0 : slot_cnt_reg + 1'b1;
    digit_next    = slot_wrap ? digit_reg + 3'd1 : digit_reg;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_BLANK: if (slot_cnt_reg == BLANK_LAST) state_next = S_DRIVE;
      S_DRIVE: if (slot_wrap)                  state_next = S_BLANK;
      default:                                 state_next = S_BLANK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double buffer: shadow loads from pending only at the frame boundary, and a
  // strobe in that same cycle lands in pending for the following frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_data_next   = pend_data_reg;
    pend_dp_next     = pend_dp_reg;
    pend_en_next     = pend_en_reg;
    pend_next        = pend_reg;
    shadow_data_next = shadow_data_reg;
    shadow_dp_next   = shadow_dp_reg;
    shadow_en_next   = shadow_en_reg;
    if (frame_bnd && pend_reg) begin
      shadow_data_next = pend_data_reg;
      shadow_dp_next   = pend_dp_reg;
      shadow_en_next   = pend_en_reg;
      pend_next        = 1'b0;
    end
    if (disp_update_i) begin
      pend_data_next = disp_data_i;
      pend_dp_next   = disp_dp_i;
      pend_en_next   = disp_en_i;
      pend_next      = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit nibble split and enabled-anode select
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign shadow_nib[gi] = shadow_data_reg[4*gi +: 4];
      assign digit_hit[gi]  = (digit_reg == 3'(gi)) && shadow_en_reg[gi];
    end
  endgenerate

  assign cur_nib = shadow_nib[digit_reg];
  assign cur_dp  = shadow_dp_reg[digit_reg];

  // Active-low gfedcba patterns
  always_comb begin
    seg_raw = 7'h7F;
    case (cur_nib)
      4'h0:    seg_raw = 7'h40;
      4'h1:    seg_raw = 7'h79;
      4'h2:    seg_raw = 7'h24;
      4'h3:    seg_raw = 7'h30;
      4'h4:    seg_raw = 7'h19;
      4'h5:    seg_raw = 7'h12;
      4'h6:    seg_raw = 7'h02;
      4'h7:    seg_raw = 7'h78;
      4'h8:    seg_raw = 7'h00;
      4'h9:    seg_raw = 7'h10;
      4'hA:    seg_raw = 7'h08;
      4'hB:    seg_raw = 7'h03;
      4'hC:    seg_raw = 7'h46;
      4'hD:    seg_raw = 7'h21;
      4'hE:    seg_raw = 7'h06;
      4'hF:    seg_raw = 7'h0E;
      default: seg_raw = 7'h7F;
    endcase
  end

`ifdef SEG7_DIM_EN
  logic [3:0] phase_reg, phase_next;
  logic [3:0] shadow_bright_reg, shadow_bright_next;

  // Phase is zero on the first drive cycle of every slot.
  always_comb begin
    phase_next         = (state_reg == S_DRIVE) ? phase_reg + 4'd1 : 4'd0;
    shadow_bright_next = frame_bnd ? brightness_i : shadow_bright_reg;
    pwm_on             = (phase_reg <= shadow_bright_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg         <= 4'd0;
      shadow_bright_reg <= 4'hF;
    end else begin
      phase_reg         <= phase_next;
      shadow_bright_reg <= shadow_bright_next;
    end
  end
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    anode_next   = 8'hFF;
    cathode_next = 8'hFF;
    if (state_reg == S_DRIVE) begin
      cathode_next = {~cur_dp, seg_raw};
      if (pwm_on) anode_next = ~digit_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_BLANK;
      slot_cnt_reg    <= '0;
      digit_reg       <= 3'd0;
      pend_data_reg   <= 32'd0;
      pend_dp_reg     <= 8'd0;
      pend_en_reg     <= 8'd0;
      pend_reg        <= 1'b0;
      shadow_data_reg <= 32'd0;
      shadow_dp_reg   <= 8'd0;
      shadow_en_reg   <= 8'd0;
      anode_reg       <= 8'hFF;
      cathode_reg     <= 8'hFF;
      frame_done_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      slot_cnt_reg    <= slot_cnt_next;
      digit_reg       <= digit_next;
      pend_data_reg   <= pend_data_next;
      pend_dp_reg     <= pend_dp_next;
      pend_en_reg     <= pend_en_next;
      pend_reg        <= pend_next;
      shadow_data_reg <= shadow_data_next;
      shadow_dp_reg   <= shadow_dp_next;
      shadow_en_reg   <= shadow_en_next;
      anode_reg       <= anode_next;
      cathode_reg     <= cathode_next;
      frame_done_reg  <= frame_bnd;
    end
  end

  assign pend_o        = pend_reg;
  assign frame_done_o  = frame_done_reg;
  assign sev_anode_o   = anode_reg;
  assign sev_cathode_o = cathode_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl against a frame-position
// reference model (PRESCALE=8, BLANK_CYC=2, 64-cycle frame).
module tb_seg7_scan_ctrl;

  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = 8 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] disp_data_i = '0;
  logic [7:0]  disp_dp_i = '0;
  logic [7:0]  disp_en_i = '0;
  logic        disp_update_i = 1'b0;
  logic [3:0]  bright_drv = 4'hF;
  logic        pend_o;
  logic        frame_done_o;
  logic [7:0]  sev_cathode_o;
  logic [7:0]  sev_anode_o;

  seg7_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B)) dut (
    .clk           (clk),
    .rst           (rst),
    .disp_data_i   (disp_data_i),
    .disp_dp_i     (disp_dp_i),
    .disp_en_i     (disp_en_i),
    .disp_update_i (disp_update_i),
`ifdef SEG7_DIM_EN
    .brightness_i  (bright_drv),
`endif
    .pend_o        (pend_o),
    .frame_done_o  (frame_done_o),
    .sev_cathode_o (sev_cathode_o),
    .sev_anode_o   (sev_anode_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycle index within the scan plus the two buffers
  int          m_t = 0;
  logic [31:0] sh_data = '0, pd_data = '0;
  logic [7:0]  sh_dp = '0, sh_en = '0, pd_dp = '0, pd_en = '0;
  logic [3:0]  sh_bright = 4'hF;
  bit          m_pend = 1'b0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (scan cycle %0d): got %h, expected %h", tag, m_t, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit upd, input logic [31:0] d,
                      input logic [7:0] dp, input logic [7:0] en);
    int pos, dig, cnt;
    logic [7:0] ea, ec;
    bit efd;
    @(negedge clk);
    rst           = r;
    disp_update_i = upd;
    disp_data_i   = upd ? d  : $urandom;
    disp_dp_i     = upd ? dp : 8'($urandom);
    disp_en_i     = upd ? en : 8'($urandom);
    if (r || upd)
      $display("txn t=%0d rst=%0d upd=%0d data=%h dp=%h en=%h", m_t, r, upd, d, dp, en);
    pos = m_t % FRAME;
    dig = pos / P;
    cnt = pos % P;
    ea  = 8'hFF;
    ec  = 8'hFF;
    efd = (pos == FRAME - 1);
    if (cnt >= B) begin
      ec = seg_tbl[sh_data[4*dig +: 4]] & (sh_dp[dig] ? 8'h7F : 8'hFF);
      if (sh_en[dig] && (((cnt - B) % 16) <= int'(sh_bright))) ea[dig] = 1'b0;
    end
    if (r) begin
      ea = 8'hFF; ec = 8'hFF; efd = 1'b0;
      m_t = 0; m_pend = 1'b0;
      sh_data = '0; sh_dp = '0; sh_en = '0;
      pd_data = '0; pd_dp = '0; pd_en = '0;
      sh_bright = 4'hF;
    end else begin
      if (efd) begin
        if (m_pend) begin
          sh_data = pd_data; sh_dp = pd_dp; sh_en = pd_en;
          m_pend = 1'b0;
        end
`ifdef SEG7_DIM_EN
        sh_bright = bright_drv;
`endif
      end
      if (upd) begin
        pd_data = d; pd_dp = dp; pd_en = en;
        m_pend = 1'b1;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
    check_val("anode", {24'd0, sev_anode_o}, {24'd0, ea});
    check_val("cathode", {24'd0, sev_cathode_o}, {24'd0, ec});
    check_val("frame_done", {31'd0, frame_done_o}, {31'd0, efd});
    check_val("pend", {31'd0, pend_o}, {31'd0, m_pend});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
  endtask

  task automatic run_to(input int pos);
    while ((m_t % FRAME) != pos) step(1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 8'd0, 8'd0);
    idle(2 * FRAME);

    // Ascending digits, all enabled
    step(1'b0, 1'b1, 32'h76543210, 8'h00, 8'hFF);
    run_to(0);
    idle(FRAME);

    // Strobe during digit 3
    run_to(3 * P + 4);
    step(1'b0, 1'b1, 32'h88888888, 8'h00, 8'hFF);
    run_to(0);
    idle(2 * FRAME);

    // Lower four digits only, dp on digit 0
    step(1'b0, 1'b1, 32'h00000000, 8'h01, 8'h0F);
    run_to(0);
    idle(FRAME);

    // Strobe in the boundary cycle itself
    step(1'b0, 1'b1, 32'hABCDEF01, 8'h80, 8'hFF);
    run_to(FRAME - 1);
    step(1'b0, 1'b1, 32'h13579BDF, 8'h24, 8'hF0);
    run_to(0);
    idle(2 * FRAME);

    for (int i = 0; i < 20 * FRAME; i++) begin
      if ($urandom_range(0, 19) == 0)
        step(1'b0, 1'b1, $urandom, 8'($urandom), 8'($urandom));
      else
        step(1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
    end

    // Reset while digit 5 is being driven
    step(1'b0, 1'b1, 32'h55555555, 8'hFF, 8'hFF);
    run_to(0);
    run_to(5 * P + 4);
    step(1'b1, 1'b0, 32'd0, 8'd0, 8'd0);
    idle(FRAME + 8);

`ifdef SEG7_DIM_EN
    bright_drv = 4'd3;
    step(1'b0, 1'b1, 32'hFEDCBA98, 8'h00, 8'hFF);
    run_to(0);
    idle(2 * FRAME);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed controller for the board's 8-digit seven-segment display.
- Sequences digit scanning, inserts an anti-ghosting blank at each digit slot, and decodes hex nibbles to segments.
- Display contents are double-buffered, so an update never tears mid-frame.
- Sits at SoC top level on the divided MCU clock; driven from debug/status nets or a GPIO-mapped register.

Parameters:
- PRESCALE, 3750, clk cycles per digit slot (≥ BLANK_CYC+2); frame = 8*PRESCALE cycles.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off (≥1).

Ports:
- clk  in  1  MCU clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- disp_data_i  in  32  nibble i (bits 4i+3:4i) shown on digit i.
- disp_dp_i  in  8  decimal point per digit, 1 = lit.
- disp_en_i  in  8  digit enable, 1 = digit may light.
- disp_update_i  in  1  single-cycle strobe that captures data/dp/en into the pending buffer.
- pend_o  out  1  pending buffer holds values not yet displayed.
- frame_done_o  out  1  one-cycle pulse at each frame boundary.
- sev_cathode_o  out  8  active-low segments: bit0=a … bit6=g, bit7=dp.
- sev_anode_o  out  8  active-low digit selects: bit i = digit i.

Behaviour:
- Reset, synchronous, in the cycle after rst is sampled high:
  - sev_anode_o=8'hFF, sev_cathode_o=8'hFF.
  - frame_done_o=0, pend_o=0.
  - Pending and shadow buffers cleared to 0, so en=0 and the display is dark.
  - slot counter=0, digit=0, state=S_BLANK.
  - rst overrides every other input, including mid-frame.
- Slot counter: runs 0..PRESCALE-1 and wraps to 0. At the wrap, digit increments modulo 8.
- FSM, two states:
  - S_BLANK: entered when the slot counter is 0. Goes to S_DRIVE when the counter reaches BLANK_CYC.
  - S_DRIVE: returns to S_BLANK at the slot wrap.
- Outputs are registered, with 1-cycle latency from state/digit to pins.
  - In S_BLANK, sev_anode_o=8'hFF and sev_cathode_o=8'hFF.
  - In S_DRIVE, anode bit[digit]=0 only if shadow_en[digit]=1. Otherwise the anode stays 8'hFF, but the slot still consumes its full time.
  - Cathode is the decode of the shadow nibble plus dp. The decode is standard hex 0-F, active-low; e.g. 0→C0, 1→F9, 8→80, A→88, F→8E with dp off. Lit dp clears bit7.
- Per-slot timing: each enabled digit is driven for exactly PRESCALE-BLANK_CYC consecutive cycles.
- Update capture:
  - disp_update_i=1 loads the pending buffer and sets pend_o in the next cycle.
  - A later strobe before the frame boundary overwrites pending (last write wins).
- Frame boundary = the cycle in which digit 7's slot wraps.
  - If pend_o=1: shadow ← pending and pend_o clears.
  - frame_done_o pulses in the same cycle.
  - New values appear from digit 0 of the next frame.
  - A strobe in the boundary cycle itself is not applied this frame. It is captured into pending, pend_o stays 1, and the value applies at the following boundary.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro SEG7_DIM_EN.
- When defined:
  - Adds port brightness_i (in, 4 bits), sampled into the shadow at the frame boundary alongside data.
  - A 4-bit PWM phase counter resets at S_DRIVE entry and increments each drive cycle, wrapping at 16.
  - The anode is asserted only while phase ≤ shadow_brightness. 15 = full on; 0 = 1 of every 16 cycles.
  - The cathode is unaffected.
  - Shadow brightness resets to 15.
- When undefined: no port, no counter; the anode is asserted for the whole S_DRIVE window.

Test Plan:
Bench uses PRESCALE=8, BLANK_CYC=2, giving a 64-cycle frame.
- Reset: hold rst 3 cycles → anode=FF, cathode=FF, pend_o=0, frame_done_o=0. Hold inputs idle for 128 cycles → anode stays FF throughout; frame_done_o pulses every 64 cycles.
- Load: data=32'h76543210, en=FF, dp=00, strobe → pend_o=1 until the boundary. Next frame:
  - digit0 gives anode FE, cathode C0 for 6 cycles, then 2 cycles of FF/FF.
  - digit1 gives FD/F9.
  - digit7 gives 7F/F8.
- Mid-frame update: during digit 3, strobe data=32'h88888888 → digits 4-7 keep old values this frame; all digits show cathode 80 from the next frame.
- Mask/dp: en=0F, dp=01 → digit0 cathode 40; anodes of digits 4-7 never low; frame length still 64.
- Boundary strobe: strobe exactly in the boundary cycle → pend_o stays 1 for one more frame; the new value appears one frame later.
- Reset mid-frame during digit 5 → anode=FF in the next cycle. After release, scan restarts at digit 0 in S_BLANK with the display dark. Under SEG7_DIM_EN, also check brightness=3 gives anode low for 4 of every 16 drive cycles.
